// File: rtl/read_config_splitter_pkg.sv
// Shared config-path definitions: bus widths, read-splitter target type,
// default address map and the out-of-bounds read filler value.
package read_config_splitter_pkg;

  localparam int AXI_ADDR_BITS  = 32;
  localparam int AXIL_DATA_BITS = 32;

  localparam int RD_CFG_NUM_CONFIGS = 3;
  localparam int RD_CFG_TGT_BITS    = $clog2(RD_CFG_NUM_CONFIGS + 1);

  // Target index; the value RD_CFG_NUM_CONFIGS marks an out-of-bounds address.
  typedef logic [RD_CFG_TGT_BITS-1:0] rd_cfg_tgt_t;

  // Ascending range bounds, index 0 is the lowest (always 0).
  localparam logic [RD_CFG_NUM_CONFIGS:0][AXI_ADDR_BITS-1:0] RD_CFG_DEFAULT_BOUNDS =
    {32'd64, 32'd48, 32'd16, 32'd0};

  localparam logic [AXIL_DATA_BITS-1:0] RD_CFG_OOB_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/read_config_decode.sv
// Address-range decoder: picks the config port owning an address and
// returns the address relative to that port's base. Purely combinational
// so the write splitter can reuse it.
module read_config_decode
  import read_config_splitter_pkg::*;
#(
  parameter int NUM_CONFIGS = RD_CFG_NUM_CONFIGS,
  parameter logic [NUM_CONFIGS:0][AXI_ADDR_BITS-1:0] BOUNDS = RD_CFG_DEFAULT_BOUNDS,
  parameter int TGT_W = $clog2(NUM_CONFIGS + 1)
) (
  input  logic [AXI_ADDR_BITS-1:0] addr_i,
  output logic [TGT_W-1:0]         tgt_o,
  output logic [AXI_ADDR_BITS-1:0] rel_addr_o
);

  // Walk ranges from the top down so the lowest range whose upper bound
  // exceeds the address wins; with B[0]=0 no lower compare is needed.
  always_comb begin
    tgt_o      = TGT_W'(NUM_CONFIGS);
    rel_addr_o = '0;
    for (int i = NUM_CONFIGS - 1; i >= 0; i--) begin
      if (addr_i < BOUNDS[i+1]) begin
        tgt_o      = TGT_W'(i);
        rel_addr_o = addr_i - BOUNDS[i];
      end
    end
  end

endmodule

// File: rtl/read_config_splitter.sv
// Read-config splitter: routes host reads to per-block config responders by
// address range and merges their replies back in request order. Only one
// target may be in flight at a time, which keeps replies ordered without a
// reorder buffer.
module read_config_splitter
  import read_config_splitter_pkg::*;
#(
  parameter int NUM_CONFIGS = RD_CFG_NUM_CONFIGS,
  parameter logic [NUM_CONFIGS:0][AXI_ADDR_BITS-1:0] ADDR_SPACE_BOUNDS = RD_CFG_DEFAULT_BOUNDS,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [AXIL_DATA_BITS-1:0] OOB_DATA = RD_CFG_OOB_DATA
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_req_valid,
  output logic                                          in_req_ready,
  input  logic [AXI_ADDR_BITS-1:0]                      in_req_addr,
  output logic                                          in_rsp_valid,
  output logic [AXIL_DATA_BITS-1:0]                     in_rsp_data,
  output logic                                          in_rsp_err,
  output logic [NUM_CONFIGS-1:0]                        out_req_valid,
  input  logic [NUM_CONFIGS-1:0]                        out_req_ready,
  output logic [NUM_CONFIGS-1:0][AXI_ADDR_BITS-1:0]     out_req_addr,
  input  logic [NUM_CONFIGS-1:0]                        out_rsp_valid,
  input  logic [NUM_CONFIGS-1:0][AXIL_DATA_BITS-1:0]    out_rsp_data
);

  localparam int TGT_W = $clog2(NUM_CONFIGS + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TGT_W-1:0] TGT_OOB = TGT_W'(NUM_CONFIGS);

  logic [TGT_W-1:0]                          dec_tgt;
  logic [AXI_ADDR_BITS-1:0]                  dec_rel;

  logic [CNT_W-1:0]                          cnt_q, cnt_d;
  logic [TGT_W-1:0]                          cur_tgt_q, cur_tgt_d;
  logic [NUM_CONFIGS-1:0]                    req_vld_q, req_vld_d;
  logic [NUM_CONFIGS-1:0][AXI_ADDR_BITS-1:0] req_addr_q, req_addr_d;
  logic                                      rsp_vld_q, rsp_vld_d;
  logic [AXIL_DATA_BITS-1:0]                 rsp_data_q, rsp_data_d;
  logic                                      rsp_err_q, rsp_err_d;

  logic [NUM_CONFIGS-1:0]                    cur_mask;
  logic [AXIL_DATA_BITS-1:0]                 cur_rsp_data;
  logic                                      rsp_hit, stray, slot_free;
  logic                                      accept, acc_oob;

  read_config_decode #(
    .NUM_CONFIGS (NUM_CONFIGS),
    .BOUNDS      (ADDR_SPACE_BOUNDS),
    .TGT_W       (TGT_W)
  ) u_decode (
    .addr_i     (in_req_addr),
    .tgt_o      (dec_tgt),
    .rel_addr_o (dec_rel)
  );

  // One-hot of the port whose replies are currently expected, plus its data.
  always_comb begin
    cur_mask     = '0;
    cur_rsp_data = '0;
    for (int i = 0; i < NUM_CONFIGS; i++) begin
      if (cnt_q != '0 && cur_tgt_q == TGT_W'(i)) begin
        cur_mask[i]  = 1'b1;
        cur_rsp_data = out_rsp_data[i];
      end
    end
  end

  assign rsp_hit   = |(out_rsp_valid & cur_mask);
  assign stray     = |(out_rsp_valid & ~cur_mask);
  // A pending downstream request blocks a new one unless it leaves this cycle.
  assign slot_free = ~|(req_vld_q & ~out_req_ready);

  assign in_req_ready = (cnt_q < CNT_W'(MAX_OUTSTANDING))
                     && (cnt_q == '0 || dec_tgt == cur_tgt_q)
                     && slot_free;
  assign accept  = in_req_valid && in_req_ready;
  assign acc_oob = accept && (dec_tgt == TGT_OOB);

  // Next-state: request slot, current target, outstanding count, response.
  always_comb begin
    req_vld_d  = req_vld_q & ~out_req_ready;
    req_addr_d = req_addr_q;
    cur_tgt_d  = cur_tgt_q;
    cnt_d      = cnt_q;
    rsp_vld_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    if (accept) begin
      cur_tgt_d = dec_tgt;
      for (int i = 0; i < NUM_CONFIGS; i++) begin
        if (dec_tgt == TGT_W'(i)) begin
          req_vld_d[i]  = 1'b1;
          req_addr_d[i] = dec_rel;
        end
      end
    end

    // rsp_hit needs cnt>0 with a real target; an OOB accept needs cnt==0 or
    // an OOB target, so the two never coincide.
    if (rsp_hit) begin
      rsp_vld_d  = 1'b1;
      rsp_data_d = cur_rsp_data;
      rsp_err_d  = 1'b0;
    end else if (acc_oob) begin
      rsp_vld_d  = 1'b1;
      rsp_data_d = OOB_DATA;
      rsp_err_d  = 1'b1;
    end

    // An OOB read is accepted and answered in the same step, so it never
    // occupies a slot.
    unique case ({accept && !acc_oob, rsp_hit})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      cur_tgt_q  <= '0;
      req_vld_q  <= '0;
      req_addr_q <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_tgt_q  <= cur_tgt_d;
      req_vld_q  <= req_vld_d;
      req_addr_q <= req_addr_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Flag downstream replies nobody is waiting for; they are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!stray) else $warning("read_config_splitter: stray downstream response dropped");
    end
  end

  assign out_req_valid = req_vld_q;
  assign out_req_addr  = req_addr_q;
  assign in_rsp_valid  = rsp_vld_q;
  assign in_rsp_data   = rsp_data_q;
  assign in_rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_read_config_splitter.sv
// Bench for read_config_splitter: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the splitter.
module tb_read_config_splitter;
  import read_config_splitter_pkg::*;

  localparam int N   = 3;
  localparam int MAX = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_req_valid;
  logic                 in_req_ready;
  logic [31:0]          in_req_addr;
  logic                 in_rsp_valid;
  logic [31:0]          in_rsp_data;
  logic                 in_rsp_err;
  logic [N-1:0]         out_req_valid;
  logic [N-1:0]         out_req_ready;
  logic [N-1:0][31:0]   out_req_addr;
  logic [N-1:0]         out_rsp_valid;
  logic [N-1:0][31:0]   out_rsp_data;

  always #5 clk = ~clk;

  read_config_splitter #(
    .NUM_CONFIGS       (N),
    .ADDR_SPACE_BOUNDS ({32'd64, 32'd48, 32'd16, 32'd0}),
    .MAX_OUTSTANDING   (MAX),
    .OOB_DATA          (32'hDEADBEEF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_req_valid  (in_req_valid),
    .in_req_ready  (in_req_ready),
    .in_req_addr   (in_req_addr),
    .in_rsp_valid  (in_rsp_valid),
    .in_rsp_data   (in_rsp_data),
    .in_rsp_err    (in_rsp_err),
    .out_req_valid (out_req_valid),
    .out_req_ready (out_req_ready),
    .out_req_addr  (out_req_addr),
    .out_rsp_valid (out_rsp_valid),
    .out_rsp_data  (out_rsp_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: outstanding real reads, last accepted target, per-port queue of
  // requests not yet handed downstream, per-port queue of handed-off
  // requests the responders still owe, and the expected upstream reply.
  int          outst;
  int          cur_t;
  logic [31:0] reqq[N][$];
  logic [31:0] rq[N][$];
  logic        exp_v;
  logic [31:0] exp_d;
  logic        exp_e;
  int          B[4] = '{0, 16, 48, 64};

  function automatic int tgt_of(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if (a < 32'(B[i+1])) return i;
    return N;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    in_req_valid  = 1'b0;
    in_req_addr   = '0;
    out_req_ready = '1;
    out_rsp_valid = '0;
    out_rsp_data  = '0;
  endtask

  task automatic rsp(input int p);
    if (rq[p].size() > 0) begin
      out_rsp_valid[p] = 1'b1;
      out_rsp_data[p]  = 32'hA000_0000 | (32'(p) << 16) | {16'h0, rq[p][0][15:0]};
    end
  endtask

  task automatic model_reset();
    outst = 0;
    cur_t = 0;
    exp_v = 1'b0;
    exp_d = '0;
    exp_e = 1'b0;
    for (int p = 0; p < N; p++) reqq[p].delete();
  endtask

  // One clock: inputs are already driven (just after a negedge).
  task automatic step();
    int          mt;
    logic [31:0] mrel;
    logic        slot_free, eready, acc, legit;
    logic [31:0] rdata;
    logic        hs[N];
    logic [31:0] hs_addr[N];
    logic        pop[N];
    #1;
    mt   = tgt_of(in_req_addr);
    mrel = (mt < N) ? in_req_addr - 32'(B[mt]) : 32'h0;
    slot_free = 1'b1;
    for (int p = 0; p < N; p++)
      if (reqq[p].size() > 0 && !out_req_ready[p]) slot_free = 1'b0;
    eready = (outst < MAX) && (outst == 0 || mt == cur_t) && slot_free;
    if (!rst) chk("in_req_ready", in_req_ready, eready);
    acc   = !rst && in_req_valid && eready;
    legit = !rst && outst > 0 && cur_t < N && out_rsp_valid[cur_t];
    rdata = legit ? out_rsp_data[cur_t] : 32'h0;
    for (int p = 0; p < N; p++) begin
      hs[p]      = !rst && reqq[p].size() > 0 && out_req_ready[p];
      hs_addr[p] = out_req_addr[p];
      pop[p]     = out_rsp_valid[p] && rq[p].size() > 0;
    end
    @(posedge clk);
    for (int p = 0; p < N; p++) if (pop[p]) void'(rq[p].pop_front());
    if (rst) begin
      model_reset();
    end else begin
      for (int p = 0; p < N; p++) begin
        if (hs[p]) begin
          void'(reqq[p].pop_front());
          rq[p].push_back(hs_addr[p]);
        end
      end
      exp_v = 1'b0;
      if (legit) begin
        exp_v = 1'b1; exp_d = rdata; exp_e = 1'b0;
        outst--;
      end
      if (acc) begin
        cur_t = mt;
        if (mt == N) begin
          exp_v = 1'b1; exp_d = 32'hDEADBEEF; exp_e = 1'b1;
        end else begin
          reqq[mt].push_back(mrel);
          outst++;
        end
      end
    end
    @(negedge clk);
    chk("in_rsp_valid", in_rsp_valid, exp_v);
    chk("in_rsp_data", in_rsp_data, exp_d);
    chk("in_rsp_err", in_rsp_err, exp_e);
    for (int p = 0; p < N; p++) begin
      chk($sformatf("out_req_valid[%0d]", p), out_req_valid[p], reqq[p].size() > 0);
      if (reqq[p].size() > 0)
        chk($sformatf("out_req_addr[%0d]", p), out_req_addr[p], reqq[p][0]);
    end
  endtask

  task automatic drain();
    int  k = 0;
    bit  busy;
    busy = 1'b1;
    while (busy && k < 100) begin
      idle();
      for (int p = 0; p < N; p++) rsp(p);
      step();
      k++;
      busy = outst > 0;
      for (int p = 0; p < N; p++) if (reqq[p].size() > 0 || rq[p].size() > 0) busy = 1'b1;
    end
    chk("drain_within_budget", k < 100, 1);
  endtask

  task automatic rand_drive();
    in_req_valid = ($urandom % 3) != 0;
    in_req_addr  = $urandom_range(0, 79);
    out_rsp_valid = '0;
    for (int p = 0; p < N; p++) begin
      out_req_ready[p] = ($urandom % 4) != 0;
      out_rsp_data[p]  = $urandom;
      if (($urandom % 3) == 0) rsp(p);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    chk("reset_rsp_valid", in_rsp_valid, 0);
    chk("reset_rsp_data", in_rsp_data, 0);
    chk("reset_rsp_err", in_rsp_err, 0);
    chk("reset_req_valid", out_req_valid, 0);
    for (int p = 0; p < N; p++) chk("reset_req_addr", out_req_addr[p], 0);

    // 1: single read of 20 -> port1 offset 4, reply 0x1234
    idle(); in_req_valid = 1'b1; in_req_addr = 20; step();
    chk("t1_req_valid", out_req_valid, 3'b010);
    chk("t1_req_addr", out_req_addr[1], 4);
    idle(); step();
    idle(); out_rsp_valid[1] = 1'b1; out_rsp_data[1] = 32'h1234; step();
    chk("t1_rsp_valid", in_rsp_valid, 1);
    chk("t1_rsp_data", in_rsp_data, 32'h1234);
    chk("t1_rsp_err", in_rsp_err, 0);
    idle(); step();

    // 2: fill four slots on port2, fifth read waits for one reply
    for (int a = 50; a <= 53; a++) begin
      idle(); in_req_valid = 1'b1; in_req_addr = 32'(a); step();
    end
    idle(); in_req_valid = 1'b1; in_req_addr = 54;
    #1 chk("t2_full_ready", in_req_ready, 0);
    step();
    idle(); in_req_valid = 1'b1; in_req_addr = 54; rsp(2); step();
    chk("t2_first_rsp", in_rsp_data, 32'hA002_0002);
    idle(); in_req_valid = 1'b1; in_req_addr = 54;
    #1 chk("t2_ready_after_rsp", in_req_ready, 1);
    step();
    drain();

    // 3: read to another port held until the first reply
    idle(); in_req_valid = 1'b1; in_req_addr = 5; step();
    idle(); in_req_valid = 1'b1; in_req_addr = 40;
    #1 chk("t3_blocked", in_req_ready, 0);
    step();
    idle(); in_req_valid = 1'b1; in_req_addr = 40; step();
    idle(); in_req_valid = 1'b1; in_req_addr = 40; rsp(0); step();
    idle(); in_req_valid = 1'b1; in_req_addr = 40; step();
    chk("t3_req_valid", out_req_valid, 3'b010);
    chk("t3_req_addr", out_req_addr[1], 24);
    drain();

    // 4: out-of-bounds read
    idle(); in_req_valid = 1'b1; in_req_addr = 70; step();
    chk("t4_no_req", out_req_valid, 0);
    chk("t4_rsp_valid", in_rsp_valid, 1);
    chk("t4_rsp_data", in_rsp_data, 32'hDEADBEEF);
    chk("t4_rsp_err", in_rsp_err, 1);
    idle(); step();

    // 5: stalled request stays stable; accept+reply together keeps count
    idle(); out_req_ready[0] = 1'b0; in_req_valid = 1'b1; in_req_addr = 9; step();
    repeat (5) begin
      idle(); out_req_ready[0] = 1'b0; step();
      chk("t5_hold_valid", out_req_valid[0], 1);
      chk("t5_hold_addr", out_req_addr[0], 9);
    end
    idle(); in_req_valid = 1'b1; in_req_addr = 1; step();
    idle(); in_req_valid = 1'b1; in_req_addr = 2; rsp(0); step();
    idle(); in_req_valid = 1'b1; in_req_addr = 3; step();
    idle(); in_req_valid = 1'b1; in_req_addr = 4; step();
    idle(); in_req_valid = 1'b1; in_req_addr = 5;
    #1 chk("t5_full_after_overlap", in_req_ready, 0);
    step();
    drain();

    // 6: reset with reads outstanding; late replies are dropped
    for (int a = 16; a <= 18; a++) begin
      idle(); in_req_valid = 1'b1; in_req_addr = 32'(a); step();
    end
    idle(); step();
    idle(); rst = 1'b1; step();
    rst = 1'b0;
    chk("t6_req_valid", out_req_valid, 0);
    chk("t6_rsp_valid", in_rsp_valid, 0);
    chk("t6_rsp_data", in_rsp_data, 0);
    chk("t6_rsp_err", in_rsp_err, 0);
    repeat (3) begin
      idle(); rsp(1); out_rsp_valid[0] = 1'b1; step();
      chk("t6_stray_dropped", in_rsp_valid, 0);
    end
    for (int p = 0; p < N; p++) rq[p].delete();
    idle(); in_req_valid = 1'b1; in_req_addr = 33; step();
    chk("t6_after_reset_addr", out_req_addr[1], 17);
    drain();

    // randomized traffic
    repeat (1500) begin
      rand_drive();
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
